spi_xfer_ctrl: RTL and testbench

//  SPI master sequencer that drives one of SS_NUM SPI slaves, such as the bitrev peripheral, from a simple request/response pair.

---
 rtl/spi_xfer_ctrl_pkg.sv | 24 ++
 rtl/spi_xfer_ctrl_clkdiv.sv | 37 +++
 rtl/spi_xfer_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer controller.
//   state_e        : controller phase encoding (3 bits)
//   DEF_*          : default parameter values for the top level
//   ss_idx_width() : width of the slave-index port, never below 1 bit
package spi_xfer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam int DEF_DIV     = 4;
    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_SS_NUM  = 2;

    function automatic int ss_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_clkdiv.sv
// Half-period tick generator for the SPI controller.
//   clock : system clock
//   reset : synchronous, active-high
//   en    : count while high; counter returns to zero whenever en is low
//   tick  : one-cycle pulse on every DIV-th consecutive enabled cycle
module spi_xfer_ctrl_clkdiv #(
    parameter int DIV = 4,
    localparam int CNT_W = $clog2(DIV + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter also clears on its own tick, so every phase that starts
    // right after a tick gets a full DIV cycles.
    always_comb begin
        tick  = en && (cnt_q == CNT_W'(DIV - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master sequencer (mode 0, MSB-first), one transfer in flight.
//   clock, reset           : single clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake; req_data/req_len/req_ss
//                            carry payload, bit count (0 or >MAX_LEN means
//                            MAX_LEN) and slave index
//   rsp_valid/rsp_ready    : response handshake; rsp_data holds the
//                            received word, last bit in [0]
//   sck, ss, mosi, miso    : SPI pins; sck idles low, ss active-low idles
//                            all-ones, mosi idles high
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DIV     = DEF_DIV,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int SS_NUM  = DEF_SS_NUM,
    localparam int LEN_W  = $clog2(MAX_LEN) + 1,
    localparam int SS_W   = ss_idx_width(SS_NUM)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MAX_LEN-1:0] req_data,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [SS_W-1:0]    req_ss,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               sck,
    output logic [SS_NUM-1:0]  ss,
    output logic               mosi,
    input  logic               miso
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] tx_q, tx_d;
    logic [MAX_LEN-1:0] rx_q, rx_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SS_W-1:0]    ss_idx_q, ss_idx_d;
    logic               last_q, last_d;

    logic               active;
    logic               tick;
    logic [LEN_W-1:0]   eff_len;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if ((l == '0) || (l > LEN_W'(MAX_LEN))) begin
            return LEN_W'(MAX_LEN);
        end
        return l;
    endfunction

    assign active = (state_q == ST_SETUP) || (state_q == ST_HIGH) ||
                    (state_q == ST_LOW)   || (state_q == ST_HOLD);
    assign eff_len = clamp_len(req_len);

    spi_xfer_ctrl_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clock (clock),
        .reset (reset),
        .en    (active),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        ss_idx_d  = ss_idx_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // Left-align the payload so the first bit out is always
                    // the MSB of the shift register.
                    tx_d      = req_data << (LEN_W'(MAX_LEN) - eff_len);
                    rx_d      = '0;
                    bit_cnt_d = eff_len;
                    ss_idx_d  = req_ss;
                    last_d    = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // Falling edge: capture MISO (updated by the slave half a
                // period ago) and expose the next TX bit at the same time.
                if (tick) begin
                    rx_d      = {rx_q[MAX_LEN-2:0], miso};
                    tx_d      = {tx_q[MAX_LEN-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    last_d    = (bit_cnt_q == LEN_W'(1));
                    state_d   = ST_LOW;
                end
            end
            ST_LOW: begin
                // The low half-period is kept for the final bit too, so the
                // last SCK pulse has a full low phase before the hold time.
                if (tick) begin
                    state_d = last_q ? ST_HOLD : ST_HIGH;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Only the phase register needs a reset: every other register is loaded
    // on acceptance and is only observed while a transfer is active.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
        tx_q      <= tx_d;
        rx_q      <= rx_d;
        bit_cnt_q <= bit_cnt_d;
        ss_idx_q  <= ss_idx_d;
        last_q    <= last_d;
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) && !reset;
        rsp_valid = (state_q == ST_RESP);
        rsp_data  = rsp_valid ? rx_q : '0;
        sck       = (state_q == ST_HIGH);
        mosi      = active ? tx_q[MAX_LEN-1] : 1'b1;
    end

    // An out-of-range index matches no line, so all selects stay high.
    always_comb begin
        ss = '1;
        for (int i = 0; i < SS_NUM; i++) begin
            if (active && (ss_idx_q == SS_W'(i))) begin
                ss[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    int checks = 0;
    int errors = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT0: DIV=4, MAX_LEN=16, SS_NUM=2
    logic        r0_valid = 1'b0, r0_ready;
    logic [15:0] r0_data = '0;
    logic [4:0]  r0_len = '0;
    logic [0:0]  r0_ss = '0;
    logic        p0_valid, p0_ready = 1'b0;
    logic [15:0] p0_data;
    logic        sck0, mosi0, miso0;
    logic [1:0]  ss0;

    // DUT1: DIV=1, MAX_LEN=8, SS_NUM=3 (allows an out-of-range index)
    logic        r1_valid = 1'b0, r1_ready;
    logic [7:0]  r1_data = '0;
    logic [3:0]  r1_len = '0;
    logic [1:0]  r1_ss = '0;
    logic        p1_valid, p1_ready = 1'b0;
    logic [7:0]  p1_data;
    logic        sck1, mosi1, miso1;
    logic [2:0]  ss1;

    spi_xfer_ctrl #(.DIV(DIV0), .MAX_LEN(16), .SS_NUM(2)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(r0_valid), .req_ready(r0_ready), .req_data(r0_data),
        .req_len(r0_len), .req_ss(r0_ss),
        .rsp_valid(p0_valid), .rsp_ready(p0_ready), .rsp_data(p0_data),
        .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso0)
    );

    spi_xfer_ctrl #(.DIV(DIV1), .MAX_LEN(8), .SS_NUM(3)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_data(r1_data),
        .req_len(r1_len), .req_ss(r1_ss),
        .rsp_valid(p1_valid), .rsp_ready(p1_ready), .rsp_data(p1_data),
        .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
    );

    // MISO source: 0 = loopback, 1 = bitrev slave on ss[1] (pad pulls high
    // when not selected)
    int   miso_mode = 0;
    logic br_miso;
    assign miso0 = (miso_mode == 0) ? mosi0 :
                   ((miso_mode == 1) && !ss0[1]) ? br_miso : 1'b1;
    assign miso1 = mosi1;

    // Bitrev slave: takes 8 bits in, then returns them bit-reversed,
    // updating MISO on SCK rising edges.
    logic       ss0_1;
    logic [7:0] br_rx = '0;
    int         br_cnt = 0;
    assign ss0_1 = ss0[1];
    always @(posedge sck0 or posedge ss0_1) begin
        if (ss0_1) begin
            br_cnt  <= 0;
            br_miso <= 1'b1;
        end else begin
            if (br_cnt < 8) begin
                br_rx   <= {br_rx[6:0], mosi0};
                br_miso <= 1'b1;
            end else if (br_cnt < 16) begin
                br_miso <= br_rx[br_cnt-8];
            end
            br_cnt <= br_cnt + 1;
        end
    end

    // Pin monitors: SCK rise count, high-phase widths, selects that went low
    logic       mon_clr = 1'b0;
    logic       prev_sck = 1'b0;
    int         rises = 0, bad_high = 0, hi_run = 0;
    logic [1:0] low_mask0 = '0;
    logic [2:0] low_mask1 = '0;
    always @(posedge clock) begin
        prev_sck <= sck0;
        if (mon_clr) begin
            rises     <= 0;
            bad_high  <= 0;
            hi_run    <= 0;
            low_mask0 <= '0;
            low_mask1 <= '0;
        end else begin
            if (sck0 && !prev_sck) rises <= rises + 1;
            if (sck0) begin
                hi_run <= hi_run + 1;
            end else begin
                if (prev_sck && (hi_run != DIV0)) bad_high <= bad_high + 1;
                hi_run <= 0;
            end
            low_mask0 <= low_mask0 | ~ss0;
            low_mask1 <= low_mask1 | ~ss1;
        end
    end

    // Reference model
    function automatic int eff_len16(input int l);
        return ((l == 0) || (l > 16)) ? 16 : l;
    endfunction

    function automatic logic [15:0] loop_ref(input logic [15:0] d, input int l);
        logic [15:0] mask;
        mask = (l >= 16) ? 16'hFFFF : ((16'h1 << l) - 16'h1);
        return d & mask;
    endfunction

    function automatic logic [15:0] bitrev_ref(input logic [15:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[15-i];
        return {8'hFF, r};
    endfunction

    function automatic int lat_ref(input int l, input int div);
        return (2 * l + 2) * div + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clock);
        mon_clr = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is seen
    // (or the budget ran out), lat counted in cycles from acceptance.
    task automatic xfer0(input logic [15:0] d, input logic [4:0] l, input logic s,
                         output logic [15:0] rd, output int lat);
        int w = 0;
        r0_data = d; r0_len = l; r0_ss = s; r0_valid = 1'b1;
        while (!r0_ready && w < 1000) begin @(negedge clock); w++; end
        @(negedge clock);
        r0_valid = 1'b0;
        lat = 1;
        while (!p0_valid && lat < 2000) begin @(negedge clock); lat++; end
        rd = p0_data;
    endtask

    task automatic ack0();
        p0_ready = 1'b1;
        @(negedge clock);
        p0_ready = 1'b0;
    endtask

    task automatic xfer1(input logic [7:0] d, input logic [1:0] s,
                         output logic [7:0] rd, output int lat);
        int w = 0;
        r1_data = d; r1_len = 4'd8; r1_ss = s; r1_valid = 1'b1;
        while (!r1_ready && w < 1000) begin @(negedge clock); w++; end
        @(negedge clock);
        r1_valid = 1'b0;
        lat = 1;
        while (!p1_valid && lat < 500) begin @(negedge clock); lat++; end
        rd = p1_data;
        p1_ready = 1'b1;
        @(negedge clock);
        p1_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, rd, held;
        logic [7:0]  d1, rd1;
        logic [4:0]  l;
        logic        s;
        int          lat, w, el;
        bit          seen;

        // Reset and idle pins
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("ready_in_reset", r0_ready, 0);
        chk("ss_in_reset", ss0, 2'b11);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_sck", sck0, 0);
        chk("idle_ss", ss0, 2'b11);
        chk("idle_mosi", mosi0, 1);
        chk("idle_rsp_valid", p0_valid, 0);
        chk("idle_rsp_data", p0_data, 0);
        chk("idle_ready", r0_ready, 1);
        chk("idle_ss_dut1", ss1, 3'b111);

        // rsp_ready held high in idle must not matter
        p0_ready = 1'b1;
        repeat (3) @(negedge clock);
        p0_ready = 1'b0;
        chk("idle_rsp_ready_ignored", r0_ready, 1);

        // Loopback, len 8, 0x3C on slave 0
        miso_mode = 0;
        clear_mon();
        xfer0(16'h003C, 5'd8, 1'b0, rd, lat);
        chk("lb3c_data", rd, 16'h003C);
        chk("lb3c_latency", lat, lat_ref(8, DIV0));
        chk("lb3c_rises", rises, 8);
        chk("lb3c_high_width", bad_high, 0);
        chk("lb3c_ss_mask", low_mask0, 2'b01);
        chk("lb3c_resp_ss", ss0, 2'b11);
        chk("lb3c_resp_mosi", mosi0, 1);
        ack0();
        chk("lb3c_ready_after", r0_ready, 1);

        // Bitrev slave on ss[1]
        miso_mode = 1;
        clear_mon();
        xfer0(16'hA500, 5'd16, 1'b1, rd, lat);
        chk("bitrev_a500", rd, 16'hFFA5);
        chk("bitrev_latency", lat, lat_ref(16, DIV0));
        chk("bitrev_ss_mask", low_mask0, 2'b10);
        chk("bitrev_rises", rises, 16);
        ack0();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            clear_mon();
            xfer0(d, 5'd16, 1'b1, rd, lat);
            chk("bitrev_rand", rd, bitrev_ref(d));
            chk("bitrev_rand_mask", low_mask0, 2'b10);
            ack0();
        end

        // Backpressure: response must hold, new request must not be taken
        miso_mode = 0;
        d = 16'($urandom);
        xfer0(d, 5'd12, 1'b0, held, lat);
        chk("bp_data", held, loop_ref(d, 12));
        r0_valid = 1'b1;
        r0_data = ~d;
        r0_len = 5'd4;
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("bp_valid", p0_valid, 1);
            chk("bp_stable", p0_data, held);
            chk("bp_ready", r0_ready, 0);
        end
        r0_valid = 1'b0;
        ack0();
        repeat (10) @(negedge clock);
        chk("bp_no_new_xfer", rises, 0);
        chk("bp_no_rsp", p0_valid, 0);
        chk("bp_idle_ready", r0_ready, 1);

        // Reset after the 5th SCK rise
        clear_mon();
        r0_data = 16'h5A5A; r0_len = 5'd16; r0_ss = 1'b0; r0_valid = 1'b1;
        w = 0;
        while (!r0_ready && w < 100) begin @(negedge clock); w++; end
        @(negedge clock);
        r0_valid = 1'b0;
        w = 0;
        while (rises < 5 && w < 2000) begin @(negedge clock); w++; end
        chk("mid_reached_5", rises, 5);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ss", ss0, 2'b11);
        chk("mid_rst_sck", sck0, 0);
        chk("mid_rst_mosi", mosi0, 1);
        chk("mid_rst_ready", r0_ready, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (p0_valid) seen = 1'b1;
        end
        chk("mid_no_rsp", seen, 0);
        chk("mid_no_more_rises", rises, 5);

        // Length boundaries
        clear_mon();
        d = 16'($urandom);
        xfer0(d, 5'd0, 1'b0, rd, lat);
        chk("len0_rises", rises, 16);
        chk("len0_data", rd, d);
        ack0();
        clear_mon();
        xfer0(16'h0001, 5'd1, 1'b0, rd, lat);
        chk("len1_data", rd, 16'h0001);
        chk("len1_rises", rises, 1);
        chk("len1_latency", lat, lat_ref(1, DIV0));
        ack0();
        clear_mon();
        d = 16'($urandom);
        xfer0(d, 5'd20, 1'b1, rd, lat);
        chk("len20_rises", rises, 16);
        chk("len20_data", rd, d);
        ack0();

        // Out-of-range and top slave index on the 3-select instance, DIV=1
        clear_mon();
        d1 = 8'($urandom);
        xfer1(d1, 2'd3, rd1, lat);
        chk("ss_oor_mask", low_mask1, 3'b000);
        chk("ss_oor_data", rd1, d1);
        chk("ss_oor_latency", lat, lat_ref(8, DIV1));
        clear_mon();
        d1 = 8'($urandom);
        xfer1(d1, 2'd2, rd1, lat);
        chk("ss2_mask", low_mask1, 3'b100);
        chk("ss2_data", rd1, d1);

        // Randomised loopback transfers
        for (int i = 0; i < 10; i++) begin
            d = 16'($urandom);
            l = 5'($urandom_range(0, 31));
            s = 1'($urandom_range(0, 1));
            el = eff_len16(int'(l));
            clear_mon();
            xfer0(d, l, s, rd, lat);
            chk("rnd_data", rd, loop_ref(d, el));
            chk("rnd_latency", lat, lat_ref(el, DIV0));
            chk("rnd_rises", rises, el);
            chk("rnd_high_width", bad_high, 0);
            chk("rnd_ss_mask", low_mask0, s ? 2'b10 : 2'b01);
            ack0();
            chk("rnd_ready_after", r0_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
